// File: rtl/mux_scan_ctrl_if.sv
// Bundles the scan handshake and the mux-facing signals of mux_scan_ctrl.
// The slave modport is the sequencer side; the master modport is the controller/mux side.
interface mux_scan_ctrl_if #(
  parameter int chNo   = 4,
  parameter int dwellW = 4,
  parameter int selNo  = $clog2(chNo)
);
  // Handshake: start is a request sampled only while idle (busy=0, done=0).
  // An accepted start raises busy on the same edge. busy stays high until the
  // last channel is captured. done is a single-cycle pulse marking a valid
  // result. start seen while busy or during the done cycle is dropped, not queued.
  logic              start;
  logic [chNo-1:0]   mask;
  logic [dwellW-1:0] dwell;
  logic              y;
  logic [selNo-1:0]  sel;
  logic              ene;
  logic              busy;
  logic              done;
  logic [chNo-1:0]   result;

  modport master (
    output start, mask, dwell, y,
    input  sel, ene, busy, done, result
  );

  modport slave (
    input  start, mask, dwell, y,
    output sel, ene, busy, done, result
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans a masked set of mux channels in ascending order, holding each for dwell+1 cycles,
// and captures the mux output per channel into a registered result vector.
module mux_scan_ctrl #(
  parameter int chNo   = 4,
  parameter int dwellW = 4,
  parameter int selNo  = $clog2(chNo)
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_scan_ctrl_if.slave      bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [selNo-1:0]  sel_q, sel_nxt;
  logic              ene_q, ene_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic [chNo-1:0]   result_q, result_nxt;
  logic [chNo-1:0]   mask_q, mask_nxt;
  logic [dwellW-1:0] dwell_q, dwell_nxt;
  logic [dwellW-1:0] cnt_q, cnt_nxt;

  logic [selNo-1:0]  first_idx;
  logic [selNo-1:0]  next_idx;
  logic              next_found;

  // Descending loops so the last hit is the lowest qualifying index.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = chNo - 1; i >= 0; i--) begin
      if (bus.mask[i]) first_idx = selNo'(i);
      if (mask_q[i] && (i > int'(sel_q))) begin
        next_idx   = selNo'(i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel_q;
    ene_nxt    = ene_q;
    busy_nxt   = busy_q;
    done_nxt   = 1'b0;
    result_nxt = result_q;
    mask_nxt   = mask_q;
    dwell_nxt  = dwell_q;
    cnt_nxt    = cnt_q;
    case (state)
      IDLE: begin
        ene_nxt  = 1'b0;
        busy_nxt = 1'b0;
        if (bus.start) begin
          result_nxt = '0;
          if (bus.mask != '0) begin
            mask_nxt  = bus.mask;
            dwell_nxt = bus.dwell;
            cnt_nxt   = bus.dwell;
            sel_nxt   = first_idx;
            ene_nxt   = 1'b1;
            busy_nxt  = 1'b1;
            state_nxt = SCAN;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      SCAN: begin
        if (cnt_q != '0) begin
          cnt_nxt = cnt_q - 1'b1;
        end else begin
          // Sample y on the last hold edge of the channel, then advance or finish.
          result_nxt[sel_q] = bus.y;
          if (next_found) begin
            sel_nxt = next_idx;
            cnt_nxt = dwell_q;
          end else begin
            ene_nxt   = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_q    <= '0;
      ene_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      mask_q   <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state    <= state_nxt;
      sel_q    <= sel_nxt;
      ene_q    <= ene_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      result_q <= result_nxt;
      mask_q   <= mask_nxt;
      dwell_q  <= dwell_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

  assign bus.sel    = sel_q;
  assign bus.ene    = ene_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a behavioural mux drives y from a data word indexed by sel.
module tb_mux_scan_ctrl;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  logic [3:0] d_vec;
  logic       y_force_en;
  logic       y_force;
  int         errors;
  int         checks;
  int         pulses;
  bit         seen;

  mux_scan_ctrl_if #(.chNo(4), .dwellW(4)) bus ();

  mux_scan_ctrl #(.chNo(4), .dwellW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  assign bus.y = y_force_en ? y_force : d_vec[bus.sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start for exactly one accepted edge; returns just after that edge.
  task automatic do_start(input logic [3:0] m, input logic [3:0] dw);
    bus.start = 1'b1;
    bus.mask  = m;
    bus.dwell = dw;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.mask   = '0;
    bus.dwell  = '0;
    d_vec      = '0;
    y_force_en = 1'b0;
    y_force    = 1'b0;

    // Reset state
    #12;
    chk("rst_sel", 32'(bus.sel), 0);
    chk("rst_ene", 32'(bus.ene), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_state", 32'(state_dbg), 32'(ST_IDLE));

    // Full mask, dwell 0: one channel per cycle, done after edge E4
    d_vec = 4'b1010;
    do_start(4'b1111, 4'd0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      chk("t1_sel", 32'(bus.sel), 32'(k));
      chk("t1_ene", 32'(bus.ene), 1);
      chk("t1_busy", 32'(bus.busy), 1);
      chk("t1_done_low", 32'(bus.done), 0);
    end
    tick();
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_busy_off", 32'(bus.busy), 0);
    chk("t1_ene_off", 32'(bus.ene), 0);
    chk("t1_result", 32'(bus.result), 32'h0000000a);
    tick();
    chk("t1_done_pulse", 32'(bus.done), 0);
    chk("t1_idle", 32'(state_dbg), 32'(ST_IDLE));
    chk("t1_result_hold", 32'(bus.result), 32'h0000000a);

    // Sparse mask 1010, dwell 3: sel=1 for 4 cycles then sel=3 for 4 cycles
    d_vec = 4'b1111;
    do_start(4'b1010, 4'd3);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      chk("t2_sel", 32'(bus.sel), (k < 4) ? 32'd1 : 32'd3);
      chk("t2_busy", 32'(bus.busy), 1);
      chk("t2_done_low", 32'(bus.done), 0);
    end
    tick();
    chk("t2_done", 32'(bus.done), 1);
    chk("t2_result", 32'(bus.result), 32'h0000000a);
    tick();

    // Empty mask: immediate done, no enable, result cleared
    do_start(4'b0000, 4'd5);
    chk("t3_done", 32'(bus.done), 1);
    chk("t3_ene", 32'(bus.ene), 0);
    chk("t3_busy", 32'(bus.busy), 0);
    chk("t3_result", 32'(bus.result), 0);
    tick();
    chk("t3_done_pulse", 32'(bus.done), 0);
    chk("t3_idle", 32'(state_dbg), 32'(ST_IDLE));

    // start held high throughout a mask 1111 dwell 1 scan
    d_vec     = 4'b0110;
    bus.start = 1'b1;
    bus.mask  = 4'b1111;
    bus.dwell = 4'd1;
    pulses    = 0;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
      if (k < 8) begin
        chk("t4_sel", 32'(bus.sel), 32'(k / 2));
        chk("t4_busy", 32'(bus.busy), 1);
      end
    end
    chk("t4_done", 32'(bus.done), 1);
    chk("t4_result", 32'(bus.result), 32'h00000006);
    tick();
    chk("t4_done_start_ignored", 32'(state_dbg), 32'(ST_IDLE));
    chk("t4_busy_after_done", 32'(bus.busy), 0);
    chk("t4_pulses", 32'(pulses), 1);
    tick();
    chk("t4_restart_from_idle", 32'(state_dbg), 32'(ST_SCAN));
    chk("t4_restart_busy", 32'(bus.busy), 1);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("t4_second_done_seen", 32'(seen), 1);
    tick();

    // Async reset 3 cycles into a mask 1111 dwell 2 scan
    d_vec = 4'b1111;
    do_start(4'b1111, 4'd2);
    tick();
    tick();
    tick();
    chk("t5_sel_pre", 32'(bus.sel), 1);
    chk("t5_result_pre", 32'(bus.result), 32'h00000001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_sel", 32'(bus.sel), 0);
    chk("t5_ene", 32'(bus.ene), 0);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_done", 32'(bus.done), 0);
    chk("t5_result", 32'(bus.result), 0);
    #3;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    chk("t5_quiet_after_reset", 32'(seen), 0);
    chk("t5_idle", 32'(state_dbg), 32'(ST_IDLE));

    // Single channel, max dwell, y toggling: capture happens at edge E16
    y_force_en = 1'b1;
    y_force    = 1'b0;
    do_start(4'b0001, 4'hf);
    for (int k = 1; k <= 16; k++) begin
      y_force = (k % 2 == 0);
      if (k == 16) begin
        chk("t6_ene_last_hold", 32'(bus.ene), 1);
        chk("t6_done_low", 32'(bus.done), 0);
      end
      tick();
    end
    y_force = 1'b0;
    chk("t6_done", 32'(bus.done), 1);
    chk("t6_result", 32'(bus.result), 32'h00000001);
    tick();
    chk("t6_done_pulse", 32'(bus.done), 0);
    y_force_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that drives the select and enable inputs of the bitNo-input multiplexer.
- Steps through a masked set of mux channels, holds each channel for a programmable dwell time, and captures the mux output into a parallel result vector.
- Sits directly upstream of the mux on sel/ene and consumes its y output; presents a start/busy/done handshake to the controlling logic.

Parameters:
- chNo, 4, number of mux channels; must match the mux bitNo.
- selNo, $clog2(chNo), width of the channel select.
- dwellW, 4, width of the dwell-count input.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  scan request; sampled only in IDLE.
- mask  input  chNo  channels to scan (bit i = channel i); latched on an accepted start.
- dwell  input  dwellW  extra hold cycles per channel; latched on an accepted start.
- y  input  1  mux output.
- sel  output  selNo  channel select to the mux.
- ene  output  1  mux enable.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle completion pulse.
- result  output  chNo  captured sample per channel.

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed):
  - sel=0, ene=0, busy=0, done=0, result=0.
  - FSM=IDLE; latched mask, dwell and the dwell counter are cleared.
  - Reset asserted mid-scan aborts the scan; no partial done pulse is produced.
- FSM states:
  - IDLE: wait for start.
  - SCAN: hold the current channel and count dwell.
  - DONE: issue the completion pulse.
- IDLE:
  - ene=0, busy=0, done=0; sel holds its last value; result holds.
  - On start=1 with mask!=0: latch mask and dwell; clear result; sel=lowest set mask bit; ene=1; busy=1; counter=dwell; go to SCAN.
  - On start=1 with mask==0: clear result; go to DONE; ene and busy stay 0.
- SCAN:
  - Each channel is held for dwell+1 cycles.
  - Counter decrements each cycle while nonzero.
  - On the edge where counter==0: result[sel] <= y. Then either:
    - a higher-numbered latched mask bit remains: sel = next set bit above sel (ascending, no wrap), counter reloads the latched dwell; or
    - no higher set bit remains: ene=0, busy=0, go to DONE.
  - start, mask and dwell inputs are ignored in SCAN; a mask change mid-scan has no effect.
  - Unmasked channels are never selected; their result bits stay 0.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - start during the DONE cycle is ignored.
- Timing:
  - Start accepted at edge E0; N = popcount(mask).
  - busy/ene high from E0 until edge E0+N*(dwell+1).
  - done high in the cycle following that edge.
  - mask==0: done is high in the cycle after E0.
- Widths:
  - dwell is unsigned; dwell=0 means 1 cycle per channel; maximum hold is 2^dwellW cycles.
  - sel is always < chNo.
- Outputs are registered; no combinational path from y to any output.

Test Plan:
- chNo=4, mask=4'b1111, dwell=0, y driven as d[sel] with d=4'b1010, start pulse -> sel 0,1,2,3 on consecutive cycles with ene=1; done pulses 5 cycles after the start edge; result=4'b1010; busy low with done.
- mask=4'b1010, dwell=3, d=4'b1111 -> sel=1 for 4 cycles then sel=3 for 4 cycles; channels 0 and 2 never selected; result=4'b1010; done 9 cycles after the start edge.
- mask=0, start -> done one cycle after the start edge; ene never high; busy stays 0; result=0.
- start re-asserted every cycle during a mask=4'b1111, dwell=1 scan -> single scan of 8 cycles; exactly one done pulse; start during the DONE cycle is not accepted; the next scan begins only from IDLE.
- rst_n pulled low 3 cycles into a mask=4'b1111, dwell=2 scan -> sel, ene, busy, done and result immediately 0 (async); after release, FSM idles until a new start; no done pulse.
- mask=4'b0001, dwell=4'hF, y toggled during the hold -> result[0] equals y at the 16th hold cycle edge; done 17 cycles after the start edge.
